// File: rtl/signal_window_pkg.sv
// Shared types and constants for the tracker window record buffer.
package signal_window_pkg;

    // Native timestamp width of the upstream tracker counter.
    localparam int WIN_TS_W = 32;

    // Timestamp value the tracker reports before any window has completed.
    localparam int TS_NONE = -1;

    // Record layout at the native timestamp width; the FIFO stores this packing
    // (start in the top bits, duration below it, range flag in bit 0).
    typedef struct packed {
        logic signed [WIN_TS_W-1:0] start;
        logic        [WIN_TS_W-1:0] dur;
        logic                       in_range;
    } win_rec_t;

    // Occupancy-tracking control states of the record FIFO.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } fifo_state_e;

    // Width of one packed record for a given timestamp width.
    function automatic int rec_width(input int ts_w);
        return 2 * ts_w + 1;
    endfunction

endpackage

// File: rtl/signal_window_buffer_fifo.sv
// First-word-fall-through record FIFO with wrap-bit pointers and occupancy FSM.
module sync_rec_fifo
    import signal_window_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 65
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  level_d;
    logic         push, pop;
    fifo_state_e  state_q, state_d;

    // Pointer comparison gives full/empty; push is allowed into a full FIFO only alongside a pop.
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rd_en_i && !empty_o;
        push     = wr_en_i && (!full_o || pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_o  = wr_ptr_q - rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
    end

    // Next occupancy state follows the post-edge level so state and level never disagree.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (level_d == LVL_FULL)  state_d = FULL;
                else if (level_d == '0)   state_d = IDLE;
            end
            FULL: begin
                if (level_d != LVL_FULL)  state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Head entry falls through combinationally; zeros are shown while empty.
    always_comb begin
        valid_o   = (state_q != IDLE);
        rd_data_o = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    // Pointer and state registers; reset discards every queued entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
        end
    end

    // Record storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/signal_window_buffer.sv
// Turns each newly completed tracker window into a queued {start, duration, range} record.
module signal_window_buffer
    import signal_window_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = WIN_TS_W,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [TS_W-1:0]    time_in [1:0],
    input  logic                      range_in,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic signed [TS_W-1:0]    rec_start,
    output logic        [TS_W-1:0]    rec_dur,
    output logic                      rec_in_range,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          drop_ovf,
    output logic [CNT_W-1:0]          drop_bad,
    output logic [CNT_W-1:0]          accepted
);

    localparam int                     REC_W   = rec_width(TS_W);
    localparam logic signed [TS_W-1:0] NONE    = TS_W'(TS_NONE);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic signed [TS_W-1:0] last_end_q, last_end_d;
    logic [CNT_W-1:0]       ovf_q, ovf_d, bad_q, bad_d, acc_q, acc_d;
    logic                   new_win, bad_win, rec_ok, push_ok, ovf_hit, pop_req;
    logic [TS_W-1:0]        dur_w;
    logic [REC_W-1:0]       wr_rec, rd_rec;
    logic                   fifo_full, fifo_empty;

    // Detect a fresh end timestamp, validate the window and decide push/drop.
    always_comb begin
        new_win    = (time_in[1] != last_end_q) && (time_in[1] != NONE);
        bad_win    = (time_in[1] < time_in[0]) || (time_in[0] == NONE);
        rec_ok     = new_win && !bad_win;
        pop_req    = rec_ready && !fifo_empty;
        push_ok    = rec_ok && (!fifo_full || pop_req);
        ovf_hit    = rec_ok && fifo_full && !pop_req;
        dur_w      = TS_W'(time_in[1] - time_in[0]);
        wr_rec     = {time_in[0], dur_w, range_in};
        last_end_d = new_win ? time_in[1] : last_end_q;
    end

    // Next values of the saturating statistics counters.
    always_comb begin
        ovf_d = ovf_q;
        bad_d = bad_q;
        acc_d = acc_q;
        if (new_win && bad_win) bad_d = sat_inc(bad_q);
        if (ovf_hit)            ovf_d = sat_inc(ovf_q);
        if (push_ok)            acc_d = sat_inc(acc_q);
    end

    // Last consumed end timestamp and counters; reset re-arms detection with "no window".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_end_q <= NONE;
            ovf_q      <= '0;
            bad_q      <= '0;
            acc_q      <= '0;
        end else begin
            last_end_q <= last_end_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
            acc_q      <= acc_d;
        end
    end

    sync_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .wr_en_i   (rec_ok),
        .wr_data_i (wr_rec),
        .rd_en_i   (rec_ready),
        .rd_data_o (rd_rec),
        .valid_o   (rec_valid),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    // Unpack the head record and expose the counters.
    always_comb begin
        rec_start    = rd_rec[REC_W-1 -: TS_W];
        rec_dur      = rd_rec[TS_W:1];
        rec_in_range = rd_rec[0];
        drop_ovf     = ovf_q;
        drop_bad     = bad_q;
        accepted     = acc_q;
    end

endmodule

// File: tb/tb_signal_window_buffer.sv
// Randomised and directed bench for signal_window_buffer against a queue-based model.
module tb_signal_window_buffer;

    localparam int DEPTH = 8;
    localparam int TS_W  = 32;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [TS_W-1:0] t_in [1:0];
    logic                   range_in;
    logic                   rec_ready;
    logic                   rec_valid;
    logic signed [TS_W-1:0] rec_start;
    logic [TS_W-1:0]        rec_dur;
    logic                   rec_in_range;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       drop_ovf, drop_bad, accepted;

    signal_window_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .time_in      (t_in),
        .range_in     (range_in),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_start    (rec_start),
        .rec_dur      (rec_dur),
        .rec_in_range (rec_in_range),
        .level        (level),
        .drop_ovf     (drop_ovf),
        .drop_bad     (drop_bad),
        .accepted     (accepted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        int unsigned dur;
        bit          rng;
    } mrec_t;

    mrec_t m_q[$];
    int    m_last;
    int    m_acc, m_bad, m_ovf;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic model_reset();
        m_q.delete();
        m_last = -1;
        m_acc  = 0;
        m_bad  = 0;
        m_ovf  = 0;
    endtask

    // Advance one clock: apply the window rules to the current inputs, then settle past the edge.
    task automatic cycle();
        bit    pop, do_push;
        mrec_t r;
        int    t0, t1;
        t0      = t_in[0];
        t1      = t_in[1];
        pop     = (m_q.size() > 0) && rec_ready;
        do_push = 1'b0;
        r       = '{0, 0, 1'b0};
        if (t1 != m_last && t1 != -1) begin
            m_last = t1;
            if (t1 < t0 || t0 == -1) begin
                if (m_bad < CMAX) m_bad++;
            end else if (m_q.size() == DEPTH && !pop) begin
                if (m_ovf < CMAX) m_ovf++;
            end else begin
                r.start = t0;
                r.dur   = t1 - t0;
                r.rng   = range_in;
                do_push = 1'b1;
                if (m_acc < CMAX) m_acc++;
            end
        end
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(r);
    endtask

    task automatic test_reset();
        rst = 1'b0; t_in[0] = -1; t_in[1] = -1; range_in = 1'b0; rec_ready = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (rec_valid !== 1'b0 || level !== '0 || rec_start !== '0 || rec_dur !== '0 || rec_in_range !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b level=%0d start=%0d dur=%0d rng=%0b, required all 0",
                     rec_valid, level, rec_start, rec_dur, rec_in_range);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        n_checks++;
        if (rec_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: got %0b required 0", rec_valid);
        end
        n_checks++;
        if (accepted !== 0 || drop_bad !== 0 || drop_ovf !== 0) begin
            n_fail++; $display("FAIL idle_counters: acc=%0d bad=%0d ovf=%0d required 0/0/0", accepted, drop_bad, drop_ovf);
        end
    endtask

    task automatic test_single();
        t_in[0] = 3; t_in[1] = 7; range_in = 1'b1; rec_ready = 1'b1;
        cycle();
        n_checks++;
        if (rec_valid !== 1'b1 || rec_start !== 3 || rec_dur !== 4 || rec_in_range !== 1'b1) begin
            n_fail++;
            $display("FAIL single_record: valid=%0b start=%0d dur=%0d rng=%0b required 1/3/4/1",
                     rec_valid, rec_start, rec_dur, rec_in_range);
        end
        for (int i = 0; i < 9; i++) cycle();
        n_checks++;
        if (rec_valid !== 1'b0 || accepted !== 1) begin
            n_fail++; $display("FAIL single_once: valid=%0b acc=%0d required 0/1", rec_valid, accepted);
        end
    endtask

    task automatic test_bad_and_zero();
        t_in[0] = 9; t_in[1] = 5; range_in = 1'b0;
        cycle();
        n_checks++;
        if (rec_valid !== 1'b0 || drop_bad !== 1) begin
            n_fail++; $display("FAIL bad_window: valid=%0b bad=%0d required 0/1", rec_valid, drop_bad);
        end
        t_in[1] = 9;
        cycle();
        n_checks++;
        if (rec_valid !== 1'b1 || rec_start !== 9 || rec_dur !== 0 || accepted !== 2) begin
            n_fail++; $display("FAIL zero_dur: valid=%0b start=%0d dur=%0d acc=%0d required 1/9/0/2",
                               rec_valid, rec_start, rec_dur, accepted);
        end
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_overflow_drain();
        rec_ready = 1'b0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            t_in[0] = k; t_in[1] = k + 2; range_in = k[0];
            cycle();
        end
        n_checks++;
        if (level !== DEPTH || drop_ovf !== 3) begin
            n_fail++; $display("FAIL overflow: level=%0d ovf=%0d required %0d/3", level, drop_ovf, DEPTH);
        end
        n_checks++;
        if (accepted !== m_acc) begin
            n_fail++; $display("FAIL overflow_acc: got %0d required %0d", accepted, m_acc);
        end
        rec_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (rec_valid !== 1'b1 || rec_start !== k || rec_dur !== 2) begin
                n_fail++; $display("FAIL drain_order[%0d]: valid=%0b start=%0d dur=%0d required 1/%0d/2",
                                   k, rec_valid, rec_start, rec_dur, k);
            end
            cycle();
        end
        n_checks++;
        if (level !== 0 || rec_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: level=%0d valid=%0b required 0/0", level, rec_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int last_start;
        int unsigned last_dur;
        rec_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            t_in[0] = 100 + k; t_in[1] = 101 + k;
            cycle();
        end
        t_in[0] = 200; t_in[1] = 210; rec_ready = 1'b1;
        cycle();
        n_checks++;
        if (level !== DEPTH || drop_ovf !== 3 || rec_start !== 101) begin
            n_fail++; $display("FAIL full_push_pop: level=%0d ovf=%0d head=%0d required %0d/3/101",
                               level, drop_ovf, rec_start, DEPTH);
        end
        last_start = 0;
        last_dur   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            last_start = rec_start;
            last_dur   = rec_dur;
            cycle();
        end
        n_checks++;
        if (last_start !== 200 || last_dur !== 10 || rec_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_tail: start=%0d dur=%0d valid=%0b required 200/10/0",
                               last_start, last_dur, rec_valid);
        end
    endtask

    task automatic test_reset_mid();
        rec_ready = 1'b0; range_in = 1'b1;
        for (int k = 16; k < 20; k++) begin
            t_in[0] = k; t_in[1] = k + 2;
            cycle();
        end
        t_in[0] = 20; t_in[1] = 25;
        cycle();
        n_checks++;
        if (level !== 5) begin
            n_fail++; $display("FAIL pre_reset_level: got %0d required 5", level);
        end
        rec_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (rec_valid !== 1'b0 || level !== 0 || rec_start !== 0 || accepted !== 0 || drop_ovf !== 0 || drop_bad !== 0) begin
            n_fail++; $display("FAIL async_reset: valid=%0b level=%0d start=%0d acc=%0d ovf=%0d bad=%0d required all 0",
                               rec_valid, level, rec_start, accepted, drop_ovf, drop_bad);
        end
        model_reset();
        @(negedge clk); rst = 1'b1; rec_ready = 1'b0;
        cycle();
        n_checks++;
        if (rec_valid !== 1'b1 || rec_start !== 20 || rec_dur !== 5 || accepted !== 1) begin
            n_fail++; $display("FAIL post_reset_window: valid=%0b start=%0d dur=%0d acc=%0d required 1/20/5/1",
                               rec_valid, rec_start, rec_dur, accepted);
        end
        rec_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        int t0;
        for (int i = 0; i < 400; i++) begin
            rec_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                t0       = int'($urandom_range(0, 41)) - 1;
                t_in[0]  = t0;
                t_in[1]  = ($urandom_range(0, 9) == 0) ? -1 : t0 + int'($urandom_range(0, 12)) - 3;
                range_in = $urandom_range(0, 1) == 1;
            end
            cycle();
            n_checks++;
            if (rec_valid !== (m_q.size() > 0) || level !== m_q.size()) begin
                n_fail++; $display("FAIL rand_occupancy[%0d]: valid=%0b level=%0d required %0b/%0d",
                                   i, rec_valid, level, m_q.size() > 0, m_q.size());
            end
            n_checks++;
            if (accepted !== m_acc || drop_bad !== m_bad || drop_ovf !== m_ovf) begin
                n_fail++; $display("FAIL rand_counters[%0d]: acc=%0d bad=%0d ovf=%0d required %0d/%0d/%0d",
                                   i, accepted, drop_bad, drop_ovf, m_acc, m_bad, m_ovf);
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if (rec_start !== m_q[0].start || rec_dur !== m_q[0].dur || rec_in_range !== m_q[0].rng) begin
                    n_fail++; $display("FAIL rand_head[%0d]: start=%0d dur=%0d rng=%0b required %0d/%0d/%0b",
                                       i, rec_start, rec_dur, rec_in_range, m_q[0].start, m_q[0].dur, m_q[0].rng);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_and_zero();
        test_overflow_drain();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_window_buffer.md
Name: signal_window_buffer

Overview:
- Sits directly downstream of signal_tracker and consumes its time_out[1:0] timestamp pair and range_out flag.
- Detects each newly completed tracking window and converts it into a record: start time, duration and in-range flag.
- Queues records in a FIFO and drains them to the trace/export logic over a valid/ready handshake.
- Counts records dropped to overflow or malformed timestamps.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- TS_W, 32: timestamp width; matches the signed integer counter.
- CNT_W, 16: width of the drop and accepted-record counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- time_in[1:0]  in  2 x TS_W signed  from tracker time_out; [0] = window start, [1] = window end; -1 = no window yet
- range_in  in  1  from tracker range_out; value-in-range flag for the window
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_start  out  TS_W signed  head record start time
- rec_dur  out  TS_W unsigned  head record duration, end - start
- rec_in_range  out  1  head record range flag
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- drop_ovf  out  CNT_W  records lost because the FIFO was full; saturating
- drop_bad  out  CNT_W  windows rejected because end < start; saturating
- accepted  out  CNT_W  records pushed; saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied, rec_valid=0, rec_start=0, rec_dur=0, rec_in_range=0, level=0.
  - All counters 0.
  - Internal last_end register = -1.
  - On release, operation starts at the first rising clk edge.
- Window detection:
  - Each cycle, new_win = (time_in[1] != last_end) && (time_in[1] != -1).
  - When new_win is true, last_end <= time_in[1] at that edge.
  - Each end timestamp is consumed exactly once; holding the same value produces no further records.
- Validation:
  - If time_in[1] < time_in[0] (signed compare), or time_in[0] == -1: no push; drop_bad++.
  - Otherwise the record is {start=time_in[0], dur=time_in[1]-time_in[0], in_range=range_in}.
  - range_in is sampled in the same cycle as new_win.
  - end == start is legal and gives dur = 0.
- Push:
  - A valid record is written on the edge where new_win holds; accepted++.
  - If the FIFO is full and no pop occurs in that cycle, the record is discarded and drop_ovf++; contents are unchanged.
  - Full with a simultaneous pop: push succeeds, level unchanged.
- Pop:
  - Occurs on a clock edge where rec_valid && rec_ready.
  - rec_* always show the head entry combinationally from storage; it is first-word-fall-through.
  - Push-to-visible latency is 1 cycle: rec_valid rises the cycle after the push edge.
  - Empty with a simultaneous push: rec_valid rises the next cycle; no bypass.
  - rec_ready while empty is ignored.
- Handshake:
  - rec_* are stable while rec_valid && !rec_ready.
  - rec_valid never drops without a pop.
- Pointers: read and write pointers of clog2(DEPTH)+1 bits, wrapping naturally; full/empty derived from the MSB comparison.
- Counters saturate at 2^CNT_W-1 and never wrap.
- State machine, per-cycle control FSM:
  - IDLE (empty) -> ACTIVE on push.
  - ACTIVE -> FULL when level reaches DEPTH.
  - FULL -> ACTIVE on pop.
  - ACTIVE -> IDLE when the last entry is popped.
  - The state is consistent with level at all times; there is no extra latency.
- Reset mid-operation: all queued records are lost; counters clear; last_end returns to -1, so an unchanged non-(-1) time_in[1] after reset is treated as a new window.

Decomposition:
- Package signal_window_pkg holds:
  - TS_NONE = -1 constant
  - typedef win_rec_t struct {start, dur, in_range}
  - typedef fifo_state_e {IDLE, ACTIVE, FULL}
- One sub-module, sync_rec_fifo: parameterised DEPTH/width FWFT FIFO with full, empty and level outputs.
- The top level holds detection, validation and the counters.

Test Plan:
- Reset, then time_in={-1,-1} held for 20 cycles -> rec_valid=0; accepted, drop_bad and drop_ovf all 0.
- time_in={3,7}, range_in=1, held for 10 cycles, rec_ready=1 -> exactly one record {3,4,1} (rec_valid one cycle after the push edge); accepted=1.
- time_in={9,5} -> no record; drop_bad=1. Then {9,9} -> record with dur=0.
- rec_ready=0; push DEPTH+3 distinct windows {k, k+2} -> level=8, drop_ovf=3. Then rec_ready=1 -> the first 8 records drain in order, starts 0..7.
- FIFO full, new window and pop in the same cycle -> level stays 8, drop_ovf unchanged, the new record is at the tail.
- rst asserted mid-drain with 5 entries queued -> outputs immediately 0/empty. After release, time_in unchanged at {20,25} -> a new record {20,5} is pushed.
